// File: rtl/otn_serial_rx.sv
// Serial OTN frame receiver: synchronises the line, hunts for the frame-start pattern,
// delivers frame bytes and, with ARQ enabled, returns a serial ACK symbol train.
module otn_serial_rx #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          FAS_BYTES      = 6,
  parameter logic [63:0] FAS_PATTERN    = 64'h0000F6F6F6282828,
  parameter int          FRAME_BYTES    = 4158,
  parameter int          ACK_BIT_CYCLES = 1,
  parameter int          ACK_TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_otn_tx_data,
  input  logic        i_arq_en,
  input  logic        i_arq_en_valid,
  input  logic        i_crc_err,
  input  logic        i_crc_err_valid,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_flush,
  output logic        o_otn_rx_ack,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);
  typedef enum logic [2:0] {HUNT, VERIFY, CAPTURE, WAIT_CRC, ACK} state_t;

  localparam logic [2:0]  LAST_PAT  = 3'(FAS_BYTES - 1);
  localparam logic [15:0] LAST_BYTE = 16'(FRAME_BYTES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  SYM_LAST  = 8'(ACK_BIT_CYCLES - 1);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_win;
  logic [2:0]             r_bit_cnt;
  logic [2:0]             r_pat_idx;
  logic [15:0]            r_byte_idx;
  logic [15:0]            r_timer;
  logic [1:0]             r_sym;
  logic [7:0]             r_sym_cnt;
  logic                   r_result;
  logic                   r_arq;
  logic [7:0]             w_nb;
  logic                   w_bnd;
  logic                   w_ack_bad;

  // Most significant used pattern byte is index 0 (received first).
  function automatic logic [7:0] pat_byte(input logic [2:0] k);
    logic [63:0] sh;
    sh = FAS_PATTERN >> {LAST_PAT - k, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_nb      = {r_win[6:0], r_sync[SYNC_STAGES-1]};
  assign w_bnd     = (r_bit_cnt == 3'd7);
  assign w_ack_bad = ~(i_crc_err_valid & ~i_crc_err);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= HUNT;
      r_sync       <= '0;
      r_win        <= '0;
      r_bit_cnt    <= '0;
      r_pat_idx    <= '0;
      r_byte_idx   <= '0;
      r_timer      <= '0;
      r_sym        <= '0;
      r_sym_cnt    <= '0;
      r_result     <= 1'b0;
      r_arq        <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_flush      <= 1'b0;
      o_otn_rx_ack <= 1'b1;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], i_otn_tx_data};
      r_win        <= w_nb;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_flush      <= 1'b0;
      if (i_arq_en_valid) r_arq <= i_arq_en;
      case (r_state)
        HUNT: begin
          if (w_nb == pat_byte(3'd0)) begin
            r_state    <= (FAS_BYTES == 1) ? CAPTURE : VERIFY;
            r_bit_cnt  <= '0;
            r_pat_idx  <= 3'd1;
            r_byte_idx <= '0;
          end
        end
        VERIFY: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd) begin
            if (w_nb == pat_byte(r_pat_idx)) begin
              r_pat_idx <= r_pat_idx + 3'd1;
              if (r_pat_idx == LAST_PAT) r_state <= CAPTURE;
            end else begin
              o_flush <= 1'b1;
              r_state <= HUNT;
            end
          end
        end
        CAPTURE: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd) begin
            o_data       <= w_nb;
            o_data_valid <= 1'b1;
            o_sof        <= (r_byte_idx == 16'd0);
            o_eof        <= (r_byte_idx == LAST_BYTE);
            r_byte_idx   <= r_byte_idx + 16'd1;
            if (r_byte_idx == LAST_BYTE) begin
              o_frame_cnt <= sat_inc(o_frame_cnt);
              r_timer     <= '0;
              r_state     <= r_arq ? WAIT_CRC : HUNT;
            end
          end
        end
        WAIT_CRC: begin
          r_timer <= r_timer + 16'd1;
          // A result arriving on the timeout cycle still takes precedence.
          if (i_crc_err_valid || r_timer == TMO_LAST) begin
            r_result     <= ~w_ack_bad;
            r_sym        <= '0;
            r_sym_cnt    <= '0;
            o_otn_rx_ack <= 1'b0;
            r_state      <= ACK;
            if (w_ack_bad) o_err_cnt <= sat_inc(o_err_cnt);
          end
        end
        ACK: begin
          r_sym_cnt <= r_sym_cnt + 8'd1;
          if (r_sym_cnt == SYM_LAST) begin
            r_sym_cnt <= '0;
            r_sym     <= r_sym + 2'd1;
            case (r_sym)
              2'd0:    o_otn_rx_ack <= r_result;
              2'd1:    o_otn_rx_ack <= 1'b0;
              2'd2:    o_otn_rx_ack <= 1'b1;
              default: begin
                o_otn_rx_ack <= 1'b1;
                r_state      <= HUNT;
              end
            endcase
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_otn_serial_rx.sv
// Bench for otn_serial_rx: three parameterisations driven from precomputed stimulus,
// checked every cycle against a stream-level model of expected outputs.
module tb_otn_serial_rx;
  localparam int NI = 3;
  localparam int N  = 33600;
  localparam int          SYN  [NI] = '{2, 3, 2};
  localparam int          FASB [NI] = '{6, 3, 1};
  localparam logic [63:0] PAT  [NI] = '{64'h0000F6F6F6282828, 64'h0000000000B34CE1, 64'h000000000000007E};
  localparam int          FRB  [NI] = '{4158, 20, 1};
  localparam int          ABC  [NI] = '{1, 3, 1};
  localparam int          TMO  [NI] = '{1024, 16, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst [NI], t_ser [NI], t_av [NI], t_ad [NI], t_cv [NI], t_cd [NI];
  logic [7:0]  d_dat [NI];
  logic        d_val [NI], d_sof [NI], d_eof [NI], d_fl [NI], d_ack [NI];
  logic [15:0] d_fc [NI], d_ec [NI];

  otn_serial_rx u_a (
    .i_clk(clk), .i_rst(t_rst[0]), .i_otn_tx_data(t_ser[0]), .i_arq_en(t_ad[0]),
    .i_arq_en_valid(t_av[0]), .i_crc_err(t_cd[0]), .i_crc_err_valid(t_cv[0]),
    .o_data(d_dat[0]), .o_data_valid(d_val[0]), .o_sof(d_sof[0]), .o_eof(d_eof[0]),
    .o_flush(d_fl[0]), .o_otn_rx_ack(d_ack[0]), .o_frame_cnt(d_fc[0]), .o_err_cnt(d_ec[0]));

  otn_serial_rx #(.SYNC_STAGES(3), .FAS_BYTES(3), .FAS_PATTERN(64'h0000000000B34CE1),
                  .FRAME_BYTES(20), .ACK_BIT_CYCLES(3), .ACK_TIMEOUT(16)) u_b (
    .i_clk(clk), .i_rst(t_rst[1]), .i_otn_tx_data(t_ser[1]), .i_arq_en(t_ad[1]),
    .i_arq_en_valid(t_av[1]), .i_crc_err(t_cd[1]), .i_crc_err_valid(t_cv[1]),
    .o_data(d_dat[1]), .o_data_valid(d_val[1]), .o_sof(d_sof[1]), .o_eof(d_eof[1]),
    .o_flush(d_fl[1]), .o_otn_rx_ack(d_ack[1]), .o_frame_cnt(d_fc[1]), .o_err_cnt(d_ec[1]));

  otn_serial_rx #(.SYNC_STAGES(2), .FAS_BYTES(1), .FAS_PATTERN(64'h000000000000007E),
                  .FRAME_BYTES(1), .ACK_BIT_CYCLES(1), .ACK_TIMEOUT(16)) u_c (
    .i_clk(clk), .i_rst(t_rst[2]), .i_otn_tx_data(t_ser[2]), .i_arq_en(t_ad[2]),
    .i_arq_en_valid(t_av[2]), .i_crc_err(t_cd[2]), .i_crc_err_valid(t_cv[2]),
    .o_data(d_dat[2]), .o_data_valid(d_val[2]), .o_sof(d_sof[2]), .o_eof(d_eof[2]),
    .o_flush(d_fl[2]), .o_otn_rx_ack(d_ack[2]), .o_frame_cnt(d_fc[2]), .o_err_cnt(d_ec[2]));

  // Stimulus per edge t, and expected outputs observed after edge t.
  bit ser [NI][N], rs [NI][N], av [NI][N], ad [NI][N], cv [NI][N], cd [NI][N];
  bit e_val [NI][N], e_sof [NI][N], e_eof [NI][N], e_fl [NI][N], e_ack [NI][N];
  bit fce [NI][N], ece [NI][N];
  bit [7:0]  e_dat [NI][N];
  bit [15:0] e_fc [NI][N], e_ec [NI][N];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int i, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst=%0d cycle=%0d got=%0h expected=%0h", nm, i, t, act, exp);
  endtask

  function automatic logic [7:0] patb(int i, int k);
    logic [63:0] p;
    p = PAT[i] >> (8 * (FASB[i] - 1 - k));
    return p[7:0];
  endfunction

  function automatic int put_byte(int i, int p, logic [7:0] v);
    for (int j = 7; j >= 0; j--) begin
      if (p < N) ser[i][p] = v[j];
      p++;
    end
    return p;
  endfunction

  // Line bit seen after the synchroniser at edge u (zero if a reset cleared it).
  function automatic bit sbit(int i, int u);
    if (u - SYN[i] < 0) return 1'b0;
    for (int v = u - SYN[i]; v <= u - 1; v++) if (rs[i][v]) return 1'b0;
    return ser[i][u - SYN[i]];
  endfunction

  // Last eight synchronised bits at edge t, newest in bit 0.
  function automatic logic [7:0] nbyte(int i, int t);
    logic [7:0] v;
    v = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (t - j < 0) break;
      if (j > 0 && rs[i][t - j]) break;
      v[j] = sbit(i, t - j);
    end
    return v;
  endfunction

  function automatic bit arqflag(int i, int t);
    for (int u = t - 1; u >= 0; u--) begin
      if (rs[i][u]) return 1'b0;
      if (av[i][u]) return ad[i][u];
    end
    return 1'b0;
  endfunction

  task automatic walk(input int i);
    int t, u, b, st;
    bit abort, done, res;
    logic [7:0] v;
    t = 0;
    while (t < N) begin
      if (rs[i][t] || nbyte(i, t) != patb(i, 0)) begin t++; continue; end
      abort = 0; u = t; b = t;
      for (int m = 1; m < FASB[i] + FRB[i]; m++) begin
        b = t + 8 * m;
        for (u = b - 7; u <= b; u++)
          if (u >= N || rs[i][u]) begin abort = 1; break; end
        if (abort) break;
        v = nbyte(i, b);
        if (m < FASB[i]) begin
          if (v != patb(i, m)) begin e_fl[i][b] = 1; abort = 1; u = b + 1; break; end
        end else begin
          e_val[i][b] = 1; e_dat[i][b] = v;
          e_sof[i][b] = (m == FASB[i]);
          e_eof[i][b] = (m == FASB[i] + FRB[i] - 1);
        end
      end
      if (abort) begin t = u; continue; end
      fce[i][b] = 1;
      if (!arqflag(i, b)) begin t = b + 1; continue; end
      done = 0; st = 0; res = 0;
      for (u = b + 1; u < N; u++) begin
        if (rs[i][u]) break;
        if (cv[i][u]) begin res = !cd[i][u]; st = u; done = 1; break; end
        if (u - b - 1 == TMO[i] - 1) begin res = 0; st = u; done = 1; break; end
      end
      if (!done) begin t = u; continue; end
      if (!res) ece[i][st] = 1;
      for (u = st; u < st + 4 * ABC[i] && u < N; u++) begin
        if (rs[i][u]) break;
        e_ack[i][u] = ((u - st) / ABC[i] == 1) ? res : ((u - st) / ABC[i] == 3);
      end
      t = (u < st + 4 * ABC[i]) ? u : u + 1;
    end
  endtask

  task automatic rand_phase(input int i, input int p0, input int c0);
    int p, nbits, bad;
    logic [7:0] v;
    p = p0;
    while (p < N - 200) begin
      if ($urandom_range(0, 9) < 6) begin
        bad = (FASB[i] > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, FASB[i] - 1)) : -1;
        for (int k = 0; k < FASB[i]; k++) begin
          v = patb(i, k);
          if (k == bad) v = v ^ 8'h10;
          p = put_byte(i, p, v);
        end
        for (int n = 0; n < FRB[i]; n++) p = put_byte(i, p, 8'($urandom));
      end else begin
        nbits = int'($urandom_range(1, 40));
        for (int j = 0; j < nbits; j++) begin
          if (p < N) ser[i][p] = 1'($urandom);
          p++;
        end
      end
    end
    for (int t = c0; t < N; t++) begin
      if ($urandom_range(0, 59) == 0) begin av[i][t] = 1; ad[i][t] = 1'($urandom); end
      if ($urandom_range(0, 9) == 0) begin cv[i][t] = 1; cd[i][t] = 1'($urandom); end
      if ($urandom_range(0, 2999) == 0) rs[i][t] = 1;
    end
  endtask

  initial begin
    int p, cnt_v, cnt_a, cnt_e;
    logic [15:0] fc, ec;
    for (int i = 0; i < NI; i++) begin
      t_rst[i] = 1; t_ser[i] = 0; t_av[i] = 0; t_ad[i] = 0; t_cv[i] = 0; t_cd[i] = 0;
      for (int t = 0; t < N; t++) e_ack[i][t] = 1;
      for (int t = 0; t < 3; t++) rs[i][t] = 1;
    end

    // Instance A: broken pattern (4th byte 29), then one clean default frame, ARQ off.
    p = 10;
    p = put_byte(0, p, 8'hF6); p = put_byte(0, p, 8'hF6); p = put_byte(0, p, 8'hF6);
    p = put_byte(0, p, 8'h29); p = put_byte(0, p, 8'h28); p = put_byte(0, p, 8'h28);
    p = 100;
    for (int k = 0; k < 6; k++) p = put_byte(0, p, patb(0, k));
    for (int n = 0; n < 4158; n++) p = put_byte(0, p, 8'(n));
    for (int t = 200; t < N; t++) if ($urandom_range(0, 49) == 0) begin cv[0][t] = 1; cd[0][t] = 1'($urandom); end

    // Instance B: ARQ frame with CRC error, frame cut by reset, clean frame, then random.
    av[1][5] = 1; ad[1][5] = 1;
    p = 10;
    for (int k = 0; k < 3; k++) p = put_byte(1, p, patb(1, k));
    for (int n = 0; n < 20; n++) p = put_byte(1, p, 8'(n));
    cv[1][201] = 1; cd[1][201] = 1;
    p = 230;
    for (int k = 0; k < 3; k++) p = put_byte(1, p, patb(1, k));
    for (int n = 0; n < 20; n++) p = put_byte(1, p, 8'h00);
    rs[1][340] = 1;
    p = 430;
    for (int k = 0; k < 3; k++) p = put_byte(1, p, patb(1, k));
    for (int n = 0; n < 20; n++) p = put_byte(1, p, 8'(n + 40));
    rand_phase(1, 650, 650);

    // Instance C: one-byte pattern and frame; good CRC, then timeout, then random.
    av[2][5] = 1; ad[2][5] = 1;
    p = put_byte(2, 10, 8'h7E); p = put_byte(2, p, 8'h5A);
    cv[2][32] = 1; cd[2][32] = 0;
    p = put_byte(2, 40, 8'h7E); p = put_byte(2, p, 8'hC3);
    rand_phase(2, 120, 120);

    for (int i = 0; i < NI; i++) begin
      walk(i);
      fc = 0; ec = 0;
      for (int t = 0; t < N; t++) begin
        if (rs[i][t]) begin fc = 0; ec = 0; end
        else begin
          if (fce[i][t] && fc != 16'hFFFF) fc++;
          if (ece[i][t] && ec != 16'hFFFF) ec++;
        end
        e_fc[i][t] = fc; e_ec[i][t] = ec;
      end
    end

    // Hand-derived anchors for the model.
    cnt_v = 0; cnt_a = 0;
    for (int t = 0; t < N; t++) begin cnt_v += int'(e_val[0][t]); cnt_a += int'(!e_ack[0][t]); end
    chk("pin_a_flush", 0, 43, 32'(e_fl[0][43]), 32'd1);
    chk("pin_a_nbytes", 0, 0, 32'(cnt_v), 32'd4158);
    chk("pin_a_ackidle", 0, 0, 32'(cnt_a), 32'd0);
    chk("pin_a_sof", 0, 157, {23'd0, e_sof[0][157], e_dat[0][157]}, {23'd0, 1'b1, 8'h00});
    chk("pin_a_eof", 0, 33413, {23'd0, e_eof[0][33413], e_dat[0][33413]}, {23'd0, 1'b1, 8'h3D});
    chk("pin_a_fcnt", 0, N - 1, 32'(e_fc[0][N - 1]), 32'd1);
    chk("pin_b_eof", 1, 196, 32'(e_eof[1][196]), 32'd1);
    for (int t = 201; t <= 212; t++) chk("pin_b_ack", 1, t, 32'(e_ack[1][t]), 32'(t >= 210));
    chk("pin_b_ecnt", 1, 201, 32'(e_ec[1][201]), 32'd1);
    chk("pin_b_fcnt_pre", 1, 339, 32'(e_fc[1][339]), 32'd1);
    chk("pin_b_fcnt_rst", 1, 340, 32'(e_fc[1][340]), 32'd0);
    cnt_e = 0;
    for (int t = 300; t < 616; t++) cnt_e += int'(e_eof[1][t]);
    chk("pin_b_noeof", 1, 616, 32'(cnt_e), 32'd0);
    chk("pin_b_eof3", 1, 616, {30'd0, e_eof[1][616], e_fc[1][616] == 16'd1}, 32'd3);
    chk("pin_c_frame", 2, 27, {22'd0, e_sof[2][27], e_eof[2][27], e_dat[2][27]}, {22'd0, 2'b11, 8'h5A});
    for (int t = 31; t <= 36; t++) chk("pin_c_ackok", 2, t, 32'(e_ack[2][t]), 32'(t == 31 || t == 33 || t >= 35));
    for (int t = 72; t <= 77; t++) chk("pin_c_acktmo", 2, t, 32'(e_ack[2][t]), 32'(t == 72 || t >= 76));
    chk("pin_c_ecnt_ok", 2, 36, 32'(e_ec[2][36]), 32'd0);
    chk("pin_c_ecnt_tmo", 2, 73, 32'(e_ec[2][73]), 32'd1);

    for (int t = 0; t < N; t++) begin
      for (int i = 0; i < NI; i++) begin
        t_rst[i] = rs[i][t]; t_ser[i] = ser[i][t]; t_av[i] = av[i][t];
        t_ad[i] = ad[i][t]; t_cv[i] = cv[i][t]; t_cd[i] = cd[i][t];
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("data_valid", i, t, 32'(d_val[i]), 32'(e_val[i][t]));
        chk("sof", i, t, 32'(d_sof[i]), 32'(e_sof[i][t]));
        chk("eof", i, t, 32'(d_eof[i]), 32'(e_eof[i][t]));
        chk("flush", i, t, 32'(d_fl[i]), 32'(e_fl[i][t]));
        chk("ack", i, t, 32'(d_ack[i]), 32'(e_ack[i][t]));
        chk("frame_cnt", i, t, 32'(d_fc[i]), 32'(e_fc[i][t]));
        chk("err_cnt", i, t, 32'(d_ec[i]), 32'(e_ec[i][t]));
        if (e_val[i][t] || rs[i][t])
          chk("data", i, t, 32'(d_dat[i]), 32'(rs[i][t] ? 8'h00 : e_dat[i][t]));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/otn_serial_rx.md
OTN_SERIAL_RX -- requirements
Module: otn_serial_rx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SYNC_STAGES, 2, synchroniser flops on i_otn_tx_data (legal 2..4).
- FAS_BYTES, 6, frame-start pattern length in bytes (legal 1..8).
- FAS_PATTERN, 64'h0000F6F6F6282828, pattern; low FAS_BYTES bytes used; most significant used byte received first.
- FRAME_BYTES, 4158, frame bytes after pattern (legal 1..65535).
- ACK_BIT_CYCLES, 1, cycles each ACK symbol is held (legal 1..255).
- ACK_TIMEOUT, 1024, cycles to wait for CRC result (legal 1..65535).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, sole clock.
- i_rst, in, 1, reset, synchronous, active-high.
- i_otn_tx_data, in, 1, serial line, MSB-first per byte.
- i_arq_en, in, 1, ARQ enable value.
- i_arq_en_valid, in, 1, loads i_arq_en.
- i_crc_err, in, 1, CRC result, 1 = error.
- i_crc_err_valid, in, 1, qualifies i_crc_err.
- o_data, out, 8, received frame byte.
- o_data_valid, out, 1, one-cycle strobe per frame byte.
- o_sof, out, 1, with first frame byte.
- o_eof, out, 1, with last frame byte.
- o_flush, out, 1, one-cycle pulse: pattern broken, downstream discards.
- o_otn_rx_ack, out, 1, serial ACK line, idle high.
- o_frame_cnt, out, 16, frames fully received, saturating.
- o_err_cnt, out, 16, bad ACKs sent (CRC error or timeout), saturating.

Function
REQ-003 s SHALL be i_otn_tx_data delayed SYNC_STAGES cycles; window w[7:0] SHALL shift each cycle, w <= {w[6:0], s}; nb = {w[6:0], s}.
REQ-004 States SHALL be HUNT, VERIFY, CAPTURE, WAIT_CRC, ACK.
REQ-005 HUNT: when nb equals pattern byte 0 -> VERIFY (or CAPTURE if FAS_BYTES==1), bit_cnt <= 0, pattern index k <= 1.
REQ-006 In VERIFY and CAPTURE bit_cnt SHALL increment mod 8 each cycle; a byte boundary is a cycle with bit_cnt==7, byte value nb.
REQ-007 VERIFY at boundary: nb == pattern byte k -> k+1, entering CAPTURE after byte FAS_BYTES-1; mismatch -> o_flush=1 that cycle, -> HUNT.
REQ-008 CAPTURE at boundary: o_data<=nb, o_data_valid=1 next cycle; o_sof on byte index 0, o_eof on index FRAME_BYTES-1; both when FRAME_BYTES==1.
REQ-009 After last byte: o_frame_cnt increments (saturate 0xFFFF); -> WAIT_CRC if ARQ flag is 1, else HUNT.
REQ-010 ARQ flag SHALL load i_arq_en on any cycle with i_arq_en_valid; value at last-byte boundary decides.
REQ-011 WAIT_CRC: timer counts from 0; i_crc_err_valid -> ACK with result=~i_crc_err; timer reaching ACK_TIMEOUT-1 without valid -> ACK with result=0; valid on the timeout cycle SHALL win.
REQ-012 i_crc_err_valid outside WAIT_CRC SHALL be ignored.
REQ-013 ACK SHALL drive symbols start 0, result, stop 0, guard 1, each ACK_BIT_CYCLES cycles, then -> HUNT; o_otn_rx_ack=1 in all other states.
REQ-014 o_err_cnt SHALL increment (saturate) on entering ACK with result 0.
REQ-015 Serial input during WAIT_CRC and ACK SHALL be ignored (no hunting).
REQ-016 o_data_valid, o_sof, o_eof, o_flush SHALL be registered, never asserted outside their defined cycles.

Reset
REQ-017 i_rst SHALL take effect on the next i_clk edge: state HUNT, all counters and ARQ flag 0, synchroniser and w 0, o_data 0, strobes 0, o_otn_rx_ack 1, o_frame_cnt 0, o_err_cnt 0.
REQ-018 Reset mid-frame SHALL abort without o_eof, o_flush or counter updates.

Verification
REQ-019 Default params, ARQ off, pattern F6F6F6282828 + 4158 bytes 00..FF repeating -> 4158 strobes, o_sof on byte 00, o_eof on last, o_frame_cnt=1, ack line constantly 1.
REQ-020 Pattern with 4th byte 29 -> o_flush one cycle at that boundary, no o_data_valid, back to HUNT; next clean frame received normally.
REQ-021 ARQ on, i_crc_err=0 valid 5 cycles after eof -> ack 0,1,0,1 then idle 1; o_err_cnt=0.
REQ-022 ARQ on, ACK_TIMEOUT=16, no valid -> after 16 cycles ack 0,0,0,1; o_err_cnt=1.
REQ-023 ACK_BIT_CYCLES=3, CRC error -> ack line 0 for 9 cycles, then 1 guard 3 cycles.
REQ-024 i_rst asserted at byte 2000 -> no o_eof, o_frame_cnt unchanged, ack 1; subsequent frame captured correctly.
